// File: rtl/mips_reg_file.sv
// 32-entry MIPS GPR file: r0 hard-wired to zero, $sp (r29) resets to SP_INIT.
// Latency: reads are combinational, writes land on the next edge. No backpressure: every write is accepted.
module mips_reg_file #(
  parameter int              DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_3FFC,
  parameter bit              BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_addr1,
  input  logic [4:0]        rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  localparam logic [4:0] SP_IDX = 5'd29;

  // r0 has no storage; the array starts at r1.
  logic [DATA_W-1:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= (5'(i) == SP_IDX) ? SP_INIT : '0;
      end
    end else if (reg_write && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  logic [4:0]        rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = rd_addr1;
  assign rd_addr[1] = rd_addr2;
  assign rd_data1   = rd_data[0];
  assign rd_data2   = rd_data[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    // Reset and r0 override everything, so stored X never leaks out of a held-in-reset file.
    always_comb begin
      rd_data[p] = '0;
      if (!rst && (rd_addr[p] != 5'd0)) begin
        if (BYPASS && reg_write && (rd_addr[p] == wr_addr)) begin
          rd_data[p] = wr_data;
        end else begin
          rd_data[p] = regs[rd_addr[p]];
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_reg_file.sv
// Directed bench for mips_reg_file: a bypassing and a non-bypassing instance share one stimulus,
// checked every cycle against an array model plus hand-computed literal expectations.
module tb_mips_reg_file;

  localparam logic [31:0] SP_INIT = 32'h0000_3FFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] byp_rd1, byp_rd2, nb_rd1, nb_rd2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m [32];
  bit          model_valid = 1'b0;

  always #5 clk = ~clk;

  mips_reg_file #(.DATA_W(32), .SP_INIT(SP_INIT), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(byp_rd1), .rd_data2(byp_rd2)
  );

  mips_reg_file #(.DATA_W(32), .SP_INIT(SP_INIT), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(nb_rd1), .rd_data2(nb_rd2)
  );

  // Architectural model: what the register contents must be after each edge.
  always @(posedge clk) begin
    if (rst) begin
      foreach (m[i]) m[i] = 32'h0;
      m[29] = SP_INIT;
      model_valid = 1'b1;
    end else if (reg_write && wr_addr != 5'd0) begin
      m[wr_addr] = wr_data;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (rst || a == 5'd0) return 32'h0;
    if (byp && reg_write && a == wr_addr) return wr_data;
    return m[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst || model_valid) begin
      check("model byp rd1", byp_rd1, exp_rd(rd_addr1, 1'b1));
      check("model byp rd2", byp_rd2, exp_rd(rd_addr2, 1'b1));
      check("model nb rd1",  nb_rd1,  exp_rd(rd_addr1, 1'b0));
      check("model nb rd2",  nb_rd2,  exp_rd(rd_addr2, 1'b0));
    end
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    reg_write = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    edge_step();
    reg_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; reg_write = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    rd_addr1 = 5'd29; rd_addr2 = 5'd29;
    #1;
    check("reset rd1 byp", byp_rd1, 32'h0);
    check("reset rd2 nb",  nb_rd2,  32'h0);
    edge_step();
    edge_step();
    check("reset held rd1", byp_rd1, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      #1;
      check("post-reset sweep rd1", byp_rd1, (i == 29) ? SP_INIT : 32'h0);
      check("post-reset sweep nb rd2", nb_rd2, (31 - i == 29) ? SP_INIT : 32'h0);
    end

    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    do_write(5'd8, 32'hDEAD_BEEF);
    rd_addr1 = 5'd8; rd_addr2 = 5'd8;
    #1;
    check("write r8 rd1", byp_rd1, 32'hDEAD_BEEF);
    check("write r8 rd2", byp_rd2, 32'hDEAD_BEEF);
    check("write r8 nb rd1", nb_rd1, 32'hDEAD_BEEF);

    reg_write = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rd_addr1 = 5'd0;
    #1;
    check("r0 during write byp", byp_rd1, 32'h0);
    edge_step();
    reg_write = 1'b0;
    #1;
    check("r0 after write", byp_rd1, 32'h0);
    check("r0 after write nb", nb_rd1, 32'h0);

    do_write(5'd9, 32'h0000_0099);
    wr_addr = 5'd9; wr_data = 32'h1234_5678; rd_addr1 = 5'd9;
    edge_step();
    check("r9 write disabled byp", byp_rd1, 32'h0000_0099);
    check("r9 write disabled nb",  nb_rd1,  32'h0000_0099);

    do_write(5'd17, 32'h1111_1111);
    reg_write = 1'b1; wr_addr = 5'd17; wr_data = 32'hA5A5_A5A5;
    rd_addr1 = 5'd17; rd_addr2 = 5'd17;
    #1;
    check("bypass same cycle", byp_rd1, 32'hA5A5_A5A5);
    check("bypass same cycle rd2", byp_rd2, 32'hA5A5_A5A5);
    check("no-bypass old value", nb_rd1, 32'h1111_1111);
    edge_step();
    reg_write = 1'b0;
    #1;
    check("no-bypass next cycle", nb_rd1, 32'hA5A5_A5A5);

    do_write(5'd5, 32'h0000_0001);
    do_write(5'd5, 32'h0000_0002);
    rd_addr2 = 5'd5;
    #1;
    check("back-to-back last wins", nb_rd2, 32'h0000_0002);

    do_write(5'd29, 32'hCAFE_0000);
    rd_addr1 = 5'd29;
    #1;
    check("r29 written", nb_rd1, 32'hCAFE_0000);
    rst = 1'b1; reg_write = 1'b1; wr_addr = 5'd29; wr_data = 32'h0;
    #1;
    check("rst forces rd1 zero", byp_rd1, 32'h0);
    edge_step();
    rst = 1'b0; reg_write = 1'b0; rd_addr1 = 5'd29; rd_addr2 = 5'd8;
    #1;
    check("reset beats write r29", byp_rd1, SP_INIT);
    check("reset beats write r29 nb", nb_rd1, SP_INIT);
    check("reset clears r8", nb_rd2, 32'h0);

    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'(i) * 32'h0101_0101);
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      #1;
      check("sweep rd1", byp_rd1, 32'(i) * 32'h0101_0101);
      check("sweep rd2", nb_rd2, 32'(31 - i) * 32'h0101_0101);
    end

    edge_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_reg_file.md
# mips_reg_file

Architectural register file for the 32-bit single-cycle MIPS core. It holds 32 × 32-bit general-purpose registers, provides two combinational read ports for rs/rt, and one clocked write port. The write address is driven by the 5-bit RegDst select mux, which chooses rt or rd. The write data comes from the MemtoReg/JAL result path. Register $0 is hard-wired to zero, and $sp has a programmable reset value.

## Interface
- `DATA_W`, 32: register width in bits. The core uses 32 only.
- `SP_INIT`, 32'h0000_3FFC: reset value of register 29 ($sp).
- `BYPASS`, 1: when 1, a read of the register being written in the same cycle returns `wr_data`. When 0, it returns the stored old value.
- `clk` input, 1 bit: core clock. All state updates happen on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `reg_write` input, 1 bit: write enable from the control unit.
- `wr_addr` input, 5 bits: destination register, driven by the RegDst 2:1 mux.
- `wr_data` input, `DATA_W` bits: write-back value.
- `rd_addr1` input, 5 bits: rs field (instr[25:21]).
- `rd_addr2` input, 5 bits: rt field (instr[20:16]).
- `rd_data1` output, `DATA_W` bits: value of register `rd_addr1`.
- `rd_data2` output, `DATA_W` bits: value of register `rd_addr2`.

## Operation
- **Storage:** registers r1..r31 are flops. r0 has no storage and always reads 0.
- **Reset:** on a rising edge with `rst`=1, r1..r31 ← 0 except r29 ← `SP_INIT`. Any write requested in that cycle is discarded.
- **Write:** on a rising edge with `rst`=0, `reg_write`=1 and `wr_addr`≠0, then reg[`wr_addr`] ← `wr_data`.
  - A write to address 0 is silently dropped.
  - With `reg_write`=0, no register changes, whatever `wr_addr`/`wr_data` are.
- **Read:** purely combinational from `rd_addrN`, stored state and (if `BYPASS`=1) the write port. Priority is highest first:
  1. `rst`=1 → 0.
  2. `rd_addrN`=0 → 0.
  3. `BYPASS`=1 and `reg_write`=1 and `rd_addrN`=`wr_addr` → `wr_data`.
  4. Otherwise → reg[`rd_addrN`].
- Both read ports are independent. Identical addresses on both ports, or on a read port and the write port, are legal.
- There is no internal state machine. The block holds only the register array state.

## Timing
- Read latency is 0 cycles. `rd_dataN` settles combinationally within the same cycle as an address change.
- Write latency is 1 edge. Data is visible on the read ports (non-bypass path) in the cycle after the write edge.
  - With `BYPASS`=1, the value is also visible in the write cycle itself.
- **Output reset values:** while `rst`=1, both read outputs are 0.
  - In the first cycle after `rst` falls, reads return 0 for every address except 29, which returns `SP_INIT`.
- **Reset mid-operation:** if `rst` is asserted in the same cycle as a pending write, reset wins and the write is lost.
- **Simultaneous events:** a read and a write to the same register in one cycle return the old value if `BYPASS`=0 and the new value if `BYPASS`=1. No X may propagate in either case.
- **Back-to-back writes:** back-to-back writes to the same register on consecutive edges are legal. The last one wins.

## Test plan
- **Reset:** hold `rst`=1 for 2 edges, then release. Sweep `rd_addr1` 0..31 → all 0 except addr 29 = 32'h0000_3FFC. Both outputs are 0 during `rst`.
- **Write/read:** `reg_write`=1, `wr_addr`=5'd8, `wr_data`=32'hDEAD_BEEF, one edge. Next cycle `rd_addr1`=8, `rd_addr2`=8 → both 32'hDEAD_BEEF.
- **$0 protection:** write 32'hFFFF_FFFF to addr 0 with `reg_write`=1 → `rd_data1` at addr 0 stays 0. Write-disabled case: `reg_write`=0, addr 9, data 32'h1234_5678 → r9 keeps its prior value.
- **Bypass:** with `BYPASS`=1, in one cycle write addr 17 = 32'hA5A5_A5A5 and read addr 17 → 32'hA5A5_A5A5 that cycle. Repeat with `BYPASS`=0 → the old r17 value that cycle and 32'hA5A5_A5A5 in the next.
- **Reset beats write:** `rst`=1 together with `reg_write`=1, addr 29, data 32'h0 → r29 = `SP_INIT` after the edge.
- **Full sweep:** write r(i) = i×32'h0101_0101 for i=1..31 on consecutive edges, then read all pairs (i, 31−i) → every value matches and r0=0.
